// File: rtl/vasip_pkg.sv
// Shared types and constants for the vector ASIP issue path.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package vasip_pkg;

    // Default geometry
    localparam int LANES_DEF = 4;
    localparam int N_W_DEF   = 25;

    // Instruction word layout
    localparam int INSTR_W = 32;
    localparam int OPC_HI  = 31;
    localparam int OPC_LO  = 28;
    localparam int SEL_BIT = 27;
    localparam int IMM_HI  = 24;
    localparam int IMM_LO  = 0;

    typedef enum logic [3:0] {
        OP_INCRI = 4'b0000,
        OP_INCRJ = 4'b0001,
        OP_SETN  = 4'b0010,
        OP_SUMFV = 4'b0011,
        OP_MULFV = 4'b0100,
        OP_NOP   = 4'b0101,
        OP_LDV   = 4'b0110
    } opcode_e;

    typedef enum logic [1:0] {
        VOP_SUM = 2'd0,
        VOP_MUL = 2'd1,
        VOP_LD  = 2'd2
    } vec_op_e;

    // Latched description of the vector instruction being issued
    typedef struct packed {
        vec_op_e op;
        logic    sel;
    } vec_cmd_t;

    function automatic logic is_vec_opcode(input logic [3:0] opc);
        return (opc == OP_SUMFV) || (opc == OP_MULFV) || (opc == OP_LDV);
    endfunction

    function automatic vec_op_e to_vec_op(input logic [3:0] opc);
        vec_op_e v;
        case (opc)
            OP_MULFV: v = VOP_MUL;
            OP_LDV:   v = VOP_LD;
            default:  v = VOP_SUM;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/vec_beat_gen.sv
// Beat address generator: element base, lane mask and last flag for one vector op.
// Latency: outputs registered; beat 0 valid the cycle after start, next beat the cycle after advance.
// Backpressure: outputs hold while advance is low.
//
// Ports: clk, rst_n (sync, active-low); start loads beat 0 for length n;
//        advance steps to the next beat (handshake of current beat);
//        base/mask/last describe the current beat.
module vec_beat_gen
    import vasip_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int N_W   = N_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N_W-1:0]   n,
    input  logic             advance,
    output logic [N_W-1:0]   base,
    output logic [LANES-1:0] mask,
    output logic             last
);

    // One extra bit so base+LANES never wraps when compared against n
    localparam logic [N_W:0] LANES_X = (N_W+1)'(LANES);

    logic [N_W-1:0] n_q;
    logic [N_W:0]   n_start_x;
    logic [N_W:0]   n_q_x;
    logic [N_W:0]   next_base_x;

    assign n_start_x   = {1'b0, n};
    assign n_q_x       = {1'b0, n_q};
    assign next_base_x = {1'b0, base} + LANES_X;

    function automatic logic [LANES-1:0] lane_mask(input logic [N_W:0] b,
                                                   input logic [N_W:0] lim);
        logic [LANES-1:0] m;
        m = '0;
        for (int k = 0; k < LANES; k++) begin
            m[k] = (b + (N_W+1)'(k)) < lim;
        end
        return m;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n_q  <= '0;
            base <= '0;
            mask <= '0;
            last <= 1'b0;
        end else if (start) begin
            // Length frozen here for the whole instruction
            n_q  <= n;
            base <= '0;
            mask <= lane_mask('0, n_start_x);
            last <= LANES_X >= n_start_x;
        end else if (advance) begin
            if (last) begin
                // Stream done: return to the idle/reset look
                base <= '0;
                mask <= '0;
                last <= 1'b0;
            end else begin
                // Not last, so next base < n and fits in N_W bits
                base <= next_base_x[N_W-1:0];
                mask <= lane_mask(next_base_x, n_q_x);
                last <= (next_base_x + LANES_X) >= n_q_x;
            end
        end
    end

endmodule

// File: rtl/vec_issue_ctrl.sv
// Issue controller: runs scalar ops in one cycle, expands vector ops into LANES-wide beats.
// Latency: scalar result next cycle; first vector beat the cycle after acceptance.
// Backpressure: instr_ready low for the whole vector stream; beats hold while vec_ready is low.
//
// Ports: clk, rst_n (sync, active-low); instr_valid/instr_ready with opcode, op_sel, imm
//        from the decoder; vec_valid/vec_ready with vec_op, vec_sel, vec_base, vec_mask,
//        vec_last toward the vector unit; reg_n/reg_i/reg_j scalar registers; busy; illegal pulse.
module vec_issue_ctrl
    import vasip_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int N_W   = N_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [3:0]       opcode,
    input  logic             op_sel,
    input  logic [N_W-1:0]   imm,
    output logic             vec_valid,
    input  logic             vec_ready,
    output logic [1:0]       vec_op,
    output logic             vec_sel,
    output logic [N_W-1:0]   vec_base,
    output logic [LANES-1:0] vec_mask,
    output logic             vec_last,
    output logic [N_W-1:0]   reg_n,
    output logic [N_W-1:0]   reg_i,
    output logic [N_W-1:0]   reg_j,
    output logic             busy,
    output logic             illegal
);

    typedef enum logic {
        ST_IDLE,
        ST_ISSUE
    } state_e;

    state_e   state;
    vec_cmd_t cmd_q;
    logic     accept;
    logic     vec_start;
    logic     advance;

    assign accept    = instr_valid && (state == ST_IDLE);
    assign vec_start = accept && is_vec_opcode(opcode) && (reg_n != '0);
    assign advance   = (state == ST_ISSUE) && vec_ready;

    // Flow-control outputs are straight decodes of the state flop
    assign instr_ready = (state == ST_IDLE);
    assign busy        = (state == ST_ISSUE);
    assign vec_valid   = (state == ST_ISSUE);
    assign vec_op      = cmd_q.op;
    assign vec_sel     = cmd_q.sel;

    // Modulo-N increment; a zero N pins the index at 0
    function automatic logic [N_W-1:0] incr_wrap(input logic [N_W-1:0] v,
                                                 input logic [N_W-1:0] lim);
        logic [N_W:0] nxt;
        nxt = {1'b0, v} + (N_W+1)'(1);
        if (lim == '0 || nxt == {1'b0, lim}) begin
            return '0;
        end
        return nxt[N_W-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            reg_n   <= '0;
            reg_i   <= '0;
            reg_j   <= '0;
            illegal <= 1'b0;
            cmd_q   <= '{op: VOP_SUM, sel: 1'b0};
        end else begin
            illegal <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        case (opcode_e'(opcode))
                            OP_SETN: begin
                                reg_n <= imm;
                                reg_i <= '0;
                                reg_j <= '0;
                            end
                            OP_INCRI: reg_i <= incr_wrap(reg_i, reg_n);
                            OP_INCRJ: reg_j <= incr_wrap(reg_j, reg_n);
                            OP_SUMFV, OP_MULFV, OP_LDV: begin
                                // Zero-length vector op is consumed without beats
                                if (reg_n != '0) begin
                                    cmd_q <= '{op: to_vec_op(opcode), sel: op_sel};
                                    state <= ST_ISSUE;
                                end
                            end
                            OP_NOP: ;
                            default: illegal <= 1'b1;
                        endcase
                    end
                end
                ST_ISSUE: begin
                    if (vec_ready && vec_last) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    vec_beat_gen #(
        .LANES (LANES),
        .N_W   (N_W)
    ) u_beat_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (vec_start),
        .n       (reg_n),
        .advance (advance),
        .base    (vec_base),
        .mask    (vec_mask),
        .last    (vec_last)
    );

endmodule

// File: tb/tb_vec_issue_ctrl.sv
// Bench for vec_issue_ctrl: directed scenarios with literal expectations plus random traffic.
// A transaction-level model (scalar values + queue of expected beats) is compared every cycle.
module tb_vec_issue_ctrl;
    import vasip_pkg::*;

    localparam int LANES = 4;
    localparam int N_W   = 25;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             instr_valid;
    logic             instr_ready;
    logic [3:0]       opcode;
    logic             op_sel;
    logic [N_W-1:0]   imm;
    logic             vec_valid;
    logic             vec_ready;
    logic [1:0]       vec_op;
    logic             vec_sel;
    logic [N_W-1:0]   vec_base;
    logic [LANES-1:0] vec_mask;
    logic             vec_last;
    logic [N_W-1:0]   reg_n, reg_i, reg_j;
    logic             busy;
    logic             illegal;

    int checks   = 0;
    int failures = 0;

    vec_issue_ctrl #(.LANES(LANES), .N_W(N_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opcode      (opcode),
        .op_sel      (op_sel),
        .imm         (imm),
        .vec_valid   (vec_valid),
        .vec_ready   (vec_ready),
        .vec_op      (vec_op),
        .vec_sel     (vec_sel),
        .vec_base    (vec_base),
        .vec_mask    (vec_mask),
        .vec_last    (vec_last),
        .reg_n       (reg_n),
        .reg_i       (reg_i),
        .reg_j       (reg_j),
        .busy        (busy),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int base;
        int mask;
        bit last;
    } beat_t;

    beat_t  q[$];
    longint m_n, m_i, m_j;
    bit     m_ill;
    int     m_op, m_sel;
    bit     known   = 1'b0;
    bit     just_rst = 1'b0;

    task automatic model_vec(input int op, input bit sel);
        beat_t b;
        if (m_n > 0) begin
            m_op  = op;
            m_sel = sel;
            for (longint base = 0; base < m_n; base += LANES) begin
                b.base = int'(base);
                b.mask = 0;
                for (int k = 0; k < LANES; k++)
                    if (base + k < m_n) b.mask |= (1 << k);
                b.last = (base + LANES >= m_n);
                q.push_back(b);
            end
        end
    endtask

    // Compare current outputs, then advance the model by the upcoming edge
    always @(negedge clk) begin
        if (known) begin
            chk("instr_ready", instr_ready, q.size() == 0);
            chk("busy",        busy,        q.size() != 0);
            chk("vec_valid",   vec_valid,   q.size() != 0);
            chk("reg_n",       reg_n,       m_n);
            chk("reg_i",       reg_i,       m_i);
            chk("reg_j",       reg_j,       m_j);
            chk("illegal",     illegal,     m_ill);
            if (q.size() != 0) begin
                chk("vec_base", vec_base, q[0].base);
                chk("vec_mask", vec_mask, q[0].mask);
                chk("vec_last", vec_last, q[0].last);
                chk("vec_op",   vec_op,   m_op);
                chk("vec_sel",  vec_sel,  m_sel);
            end
            if (just_rst) begin
                chk("rst_vec_base", vec_base, 0);
                chk("rst_vec_mask", vec_mask, 0);
                chk("rst_vec_last", vec_last, 0);
                chk("rst_vec_op",   vec_op,   0);
                chk("rst_vec_sel",  vec_sel,  0);
            end
        end
        if (rst_n === 1'b0) begin
            q.delete();
            m_n = 0; m_i = 0; m_j = 0; m_ill = 0; m_op = 0; m_sel = 0;
            known    = 1'b1;
            just_rst = 1'b1;
        end else if (known) begin
            just_rst = 1'b0;
            m_ill    = 1'b0;
            if (q.size() != 0) begin
                if (vec_ready) void'(q.pop_front());
            end else if (instr_valid) begin
                case (opcode)
                    4'd0: m_i = (m_n == 0) ? 0 : (m_i + 1) % m_n;
                    4'd1: m_j = (m_n == 0) ? 0 : (m_j + 1) % m_n;
                    4'd2: begin m_n = imm; m_i = 0; m_j = 0; end
                    4'd3: model_vec(0, op_sel);
                    4'd4: model_vec(1, op_sel);
                    4'd5: ;
                    4'd6: model_vec(2, op_sel);
                    default: m_ill = 1'b1;
                endcase
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_instr(input logic [3:0] opc, input logic sel, input logic [N_W-1:0] immv);
        logic [INSTR_W-1:0] iw;
        iw = '0;
        iw[OPC_HI:OPC_LO] = opc;
        iw[SEL_BIT]       = sel;
        iw[IMM_HI:IMM_LO] = immv;
        opcode = iw[OPC_HI:OPC_LO];
        op_sel = iw[SEL_BIT];
        imm    = iw[IMM_HI:IMM_LO];
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance
    task automatic issue(input logic [3:0] opc, input logic sel, input logic [N_W-1:0] immv);
        int n;
        bit got;
        drive_instr(opc, sel, immv);
        instr_valid = 1'b1;
        n   = 0;
        got = 1'b0;
        while (n < 64 && !got) begin
            if (instr_ready === 1'b1) got = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        instr_valid = 1'b0;
        chk("issue_accept", got, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run exceeded time limit at %0t", $time);
        $fatal(1);
    end

    int bb[8];
    int mm[8];
    int ll[8];
    int low;

    initial begin
        rst_n = 1'b0; instr_valid = 1'b0; vec_ready = 1'b0;
        drive_instr(OP_NOP, 1'b0, '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("lit_rst_ready", instr_ready, 1);
        chk("lit_rst_valid", vec_valid, 0);

        // SETN 400
        issue(OP_SETN, 1'b0, 25'd400);
        chk("lit_setn_n", reg_n, 400);
        chk("lit_setn_i", reg_i, 0);
        chk("lit_setn_j", reg_j, 0);
        chk("lit_setn_ready", instr_ready, 1);

        // INCRI wrap with N=3
        issue(OP_SETN, 1'b0, 25'd3);
        issue(OP_INCRI, 1'b0, '0); chk("lit_incri_1", reg_i, 1);
        issue(OP_INCRI, 1'b0, '0); chk("lit_incri_2", reg_i, 2);
        issue(OP_INCRI, 1'b0, '0); chk("lit_incri_3", reg_i, 0);
        issue(OP_INCRI, 1'b0, '0); chk("lit_incri_4", reg_i, 1);
        chk("lit_incri_j", reg_j, 0);
        issue(OP_SETN, 1'b0, 25'd0);
        issue(OP_INCRI, 1'b0, '0); chk("lit_incri_n0", reg_i, 0);

        // MULFV over N=10, sink always ready
        vec_ready = 1'b1;
        issue(OP_SETN, 1'b0, 25'd10);
        issue(OP_MULFV, 1'b1, '0);
        chk("lit_mul_op", vec_op, 1);
        chk("lit_mul_sel", vec_sel, 1);
        low = 0;
        while (instr_ready === 1'b0 && low < 20) begin
            if (low < 8) begin bb[low] = vec_base; mm[low] = vec_mask; ll[low] = vec_last; end
            low++;
            @(posedge clk);
            #1;
        end
        chk("lit_mul_low", low, 3);
        chk("lit_mul_b0", bb[0], 0);  chk("lit_mul_m0", mm[0], 4'hF); chk("lit_mul_l0", ll[0], 0);
        chk("lit_mul_b1", bb[1], 4);  chk("lit_mul_m1", mm[1], 4'hF); chk("lit_mul_l1", ll[1], 0);
        chk("lit_mul_b2", bb[2], 8);  chk("lit_mul_m2", mm[2], 4'h3); chk("lit_mul_l2", ll[2], 1);

        // SUMFV over N=8 with two stall cycles on beat 0, NOP waiting
        issue(OP_SETN, 1'b0, 25'd8);
        vec_ready = 1'b0;
        issue(OP_SUMFV, 1'b0, '0);
        drive_instr(OP_NOP, 1'b0, '0);
        instr_valid = 1'b1;
        low = 0;
        while (instr_ready === 1'b0 && low < 20) begin
            vec_ready = (low >= 2);
            if (low < 8) begin bb[low] = vec_base; mm[low] = vec_mask; ll[low] = vec_last; end
            low++;
            @(posedge clk);
            #1;
        end
        chk("lit_sum_low", low, 4);
        chk("lit_sum_b0", bb[0], 0); chk("lit_sum_b1", bb[1], 0); chk("lit_sum_b2", bb[2], 0);
        chk("lit_sum_m1", mm[1], 4'hF); chk("lit_sum_l1", ll[1], 0);
        chk("lit_sum_b3", bb[3], 4); chk("lit_sum_m3", mm[3], 4'hF); chk("lit_sum_l3", ll[3], 1);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        chk("lit_nop_novec", vec_valid, 0);
        chk("lit_nop_n", reg_n, 8);

        // Zero-length LDV, then illegal opcode
        vec_ready = 1'b1;
        issue(OP_SETN, 1'b0, 25'd0);
        issue(OP_LDV, 1'b0, '0);
        for (int c = 0; c < 3; c++) begin
            chk("lit_ld0_valid", vec_valid, 0);
            chk("lit_ld0_ready", instr_ready, 1);
            @(posedge clk);
            #1;
        end
        issue(OP_SETN, 1'b0, 25'd7);
        issue(OP_INCRI, 1'b0, '0);
        issue(4'hF, 1'b1, 25'd99);
        chk("lit_ill_pulse", illegal, 1);
        chk("lit_ill_n", reg_n, 7);
        chk("lit_ill_i", reg_i, 1);
        chk("lit_ill_j", reg_j, 0);
        @(posedge clk);
        #1;
        chk("lit_ill_end", illegal, 0);

        // Reset during beat 1 of LDV
        issue(OP_SETN, 1'b0, 25'd12);
        issue(OP_LDV, 1'b0, '0);
        chk("lit_ld_b0", vec_base, 0);
        @(posedge clk);
        #1;
        chk("lit_ld_b1", vec_base, 4);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("lit_abort_valid", vec_valid, 0);
        chk("lit_abort_busy", busy, 0);
        chk("lit_abort_n", reg_n, 0);
        chk("lit_abort_ready", instr_ready, 1);
        issue(OP_SETN, 1'b0, 25'd5);
        chk("lit_after_n", reg_n, 5);

        // Random traffic, checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            int sel_op;
            rst_n       = ($urandom_range(0, 299) != 0);
            instr_valid = $urandom_range(0, 1);
            vec_ready   = ($urandom_range(0, 3) != 0);
            sel_op      = $urandom_range(0, 8);
            if (sel_op == 8) sel_op = $urandom_range(7, 15);
            drive_instr(4'(sel_op), 1'($urandom_range(0, 1)), 25'($urandom_range(0, 30)));
            @(posedge clk);
            #1;
        end
        instr_valid = 1'b0;
        vec_ready   = 1'b1;
        rst_n       = 1'b1;
        repeat (40) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
